// File: rtl/calculate_pkg.sv
// Shared opcodes, FSM states and key-folding helper
// for the multi-op locked calculate core.
package calculate_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  // Widest key difference the folder handles
  localparam int MAX_KEY = 512;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  // XOR together all width-bit lanes of diff
  function automatic logic [63:0] key_fold(
    input logic [MAX_KEY-1:0] diff,
    input int                 width
  );
    logic [63:0] m;
    logic [63:0] lane;
    m = '0;
    if (width >= 64) lane = '1;
    else lane = (64'd1 << width) - 64'd1;
    for (int c = 0; c < MAX_KEY / 8; c++) begin
      if (c * width < MAX_KEY)
        m = m ^ (64'(diff >> (c * width)) & lane);
    end
    return m;
  endfunction

endpackage

// File: rtl/calculate_seq_mul.sv
// Radix-2 shift-add multiplier, one partial
// product per cycle, WIDTH cycles per product.
module calculate_seq_mul
  import calculate_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  assign acc_d     = acc_q + (b_q[0] ? a_q : '0);
  // Final sum is visible in the last busy cycle
  assign product_o = acc_d;
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/calculate_multi_obf.sv
// Multi-op logic-locked ALU with ap_ctrl_hs
// handshake; wrong keys corrupt the result.
module calculate_multi_obf
  import calculate_pkg::*;
#(
  parameter int                   WIDTH     = 32,
  parameter int                   KEY_WIDTH = 255,
  parameter logic [KEY_WIDTH-1:0] LOCK_KEY  = '0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     s,
  input  logic [WIDTH-1:0]     e,
  input  logic [KEY_WIDTH-1:0] working_key,
  output logic [WIDTH-1:0]     ap_return
);

  localparam int SW = $clog2(WIDTH);

  state_e               state_q, state_d;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     s_q;
  logic [WIDTH-1:0]     e_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [WIDTH-1:0]     ret_q, ret_d;

  logic                 accept;
  logic [MAX_KEY-1:0]   diff;
  logic [WIDTH-1:0]     mask;
  logic [WIDTH-1:0]     raw;
  logic [SW-1:0]        shamt;
  logic                 mul_busy;
  logic                 mul_done;
  logic [WIDTH-1:0]     mul_prod;

  assign accept   = (state_q == IDLE) && ap_start;
  assign ap_idle  = (state_q == IDLE);
  assign ap_done  = (state_q == DONE);
  assign ap_ready = ap_done;
  assign ap_return = ret_q;

  assign diff  = MAX_KEY'(key_q ^ LOCK_KEY);
  assign mask  = WIDTH'(key_fold(diff, WIDTH));
  assign shamt = e_q[SW-1:0];

  calculate_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .start_i  (accept),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .a_i      (s),
    .b_i      (e),
    .product_o(mul_prod)
  );

  always_comb begin
    raw = '0;
    unique case (op_q)
      OP_ADD: raw = s_q + e_q;
      OP_SUB: raw = s_q - e_q;
      OP_AND: raw = s_q & e_q;
      OP_OR:  raw = s_q | e_q;
      OP_XOR: raw = s_q ^ e_q;
      OP_MUL: raw = mul_prod;
      OP_SLL: raw = s_q << shamt;
      OP_SRL: raw = s_q >> shamt;
      default: raw = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    unique case (state_q)
      IDLE: if (ap_start) state_d = EXEC;
      EXEC: begin
        if (op_q != OP_MUL || (mul_busy && mul_done)) begin
          state_d = DONE;
          ret_d   = raw ^ mask;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      s_q     <= '0;
      e_q     <= '0;
      key_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      if (accept) begin
        op_q  <= op;
        s_q   <= s;
        e_q   <= e;
        key_q <= working_key;
      end
    end
  end

endmodule

// File: tb/tb_calculate_multi_obf.sv
// Self-checking bench: directed vector table, handshake
// corner sequences and randomized ops vs a reference model.
module tb_calculate_multi_obf;

  localparam int W  = 32;
  localparam int KW = 255;
  localparam logic [KW-1:0] LOCK =
    {63'h1234_5678_9ABC_DEF0,
     192'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1357_9BDF_2468_ACE0_FEED_FACE};

  localparam logic [2:0] T_ADD = 3'd0;
  localparam logic [2:0] T_SUB = 3'd1;
  localparam logic [2:0] T_AND = 3'd2;
  localparam logic [2:0] T_OR  = 3'd3;
  localparam logic [2:0] T_XOR = 3'd4;
  localparam logic [2:0] T_MUL = 3'd5;
  localparam logic [2:0] T_SLL = 3'd6;
  localparam logic [2:0] T_SRL = 3'd7;

  logic          ap_clk;
  logic          ap_rst_n;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic          ap_ready;
  logic [2:0]    op;
  logic [W-1:0]  s;
  logic [W-1:0]  e;
  logic [KW-1:0] working_key;
  logic [W-1:0]  ap_return;

  int tests;
  int fails;
  int done_cnt;

  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  s;
    logic [W-1:0]  e;
    logic [KW-1:0] key;
    logic [W-1:0]  exp;
    int            lat;
  } vec_t;

  vec_t vt[$];

  calculate_multi_obf #(
    .WIDTH    (W),
    .KEY_WIDTH(KW),
    .LOCK_KEY (LOCK)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .ap_ready   (ap_ready),
    .op         (op),
    .s          (s),
    .e          (e),
    .working_key(working_key),
    .ap_return  (ap_return)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(negedge ap_clk) if (ap_done) done_cnt++;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [KW-1:0] rand_key();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[KW-1:0];
  endfunction

  // Reference: plain arithmetic plus per-bit key folding
  function automatic logic [W-1:0] model(input logic [2:0] o,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [KW-1:0] k);
    logic [63:0]   p;
    logic [W-1:0]  r;
    logic [W-1:0]  m;
    logic [KW-1:0] d;
    int            sh;
    sh = int'(b % W);
    p  = 64'(a) * 64'(b);
    case (o)
      T_ADD:   r = a + b;
      T_SUB:   r = a - b;
      T_AND:   r = a & b;
      T_OR:    r = a | b;
      T_XOR:   r = a ^ b;
      T_MUL:   r = p[W-1:0];
      T_SLL:   r = a << sh;
      default: r = a >> sh;
    endcase
    d = k ^ LOCK;
    m = '0;
    for (int i = 0; i < KW; i++)
      if (d[i]) m = m ^ (W'(1) << (i % W));
    return r ^ m;
  endfunction

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Called #1 after an edge with the DUT idle
  task automatic run_op(input string nm, input logic [2:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [KW-1:0] k, input logic [W-1:0] exp,
                        input int exp_lat);
    int   lat;
    logic idle_bad;
    chk({nm, " idle_before"}, 64'(ap_idle), 64'd1);
    op = o; s = a; e = b; working_key = k; ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    op = 3'($urandom); s = $urandom; e = $urandom;
    working_key = rand_key();
    lat = 1;
    idle_bad = 1'b0;
    while (!ap_done && lat < 100) begin
      if (ap_idle) idle_bad = 1'b1;
      step();
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " result"}, 64'(ap_return), 64'(exp));
    chk({nm, " ready"}, 64'(ap_ready), 64'(ap_done));
    chk({nm, " idle_busy"}, 64'({idle_bad, ap_idle}), 64'd0);
    step();
    chk({nm, " idle_after"}, 64'({ap_idle, ap_done}), 64'b10);
  endtask

  task automatic add_vec(input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [KW-1:0] k,
                         input logic [W-1:0] x);
    vec_t v;
    v.op = o; v.s = a; v.e = b; v.key = k; v.exp = x;
    v.lat = (o == T_MUL) ? W + 1 : 2;
    vt.push_back(v);
  endtask

  initial begin
    int dc0;
    int lat;
    tests = 0; fails = 0; done_cnt = 0;
    ap_rst_n = 1'b0; ap_start = 1'b0;
    op = '0; s = '0; e = '0; working_key = '0;

    add_vec(T_ADD, 32'hFFFF_FFFF, 32'd2, LOCK, 32'h0000_0001);
    add_vec(T_MUL, 32'h0001_0003, 32'h0002_0005, LOCK, 32'h000B_000F);
    add_vec(T_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F,
            LOCK ^ (KW'(1) << 33), 32'hFFFF_FFFD);
    add_vec(T_SUB, 32'd3, 32'd5, LOCK, 32'hFFFF_FFFE);
    add_vec(T_SRL, 32'h8000_0000, 32'h21, LOCK, 32'h4000_0000);
    add_vec(T_SLL, 32'd1, 32'd31, LOCK, 32'h8000_0000);
    add_vec(T_AND, 32'hF0F0_F0F0, 32'hFF00_FF00,
            LOCK ^ (KW'(1) << 254), 32'hB000_F000);
    add_vec(T_OR, 32'h1200_0034, 32'h0056_7800, LOCK, 32'h1256_7834);
    add_vec(T_ADD, 32'd1, 32'd1, LOCK ^ KW'(1), 32'd3);
    add_vec(T_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LOCK, 32'd1);

    repeat (3) step();
    chk("reset_return", 64'(ap_return), 64'd0);
    chk("reset_flags", 64'({ap_idle, ap_done, ap_ready}), 64'b100);
    ap_rst_n = 1'b1;
    step();

    for (int i = 0; i < vt.size(); i++)
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].s, vt[i].e,
             vt[i].key, vt[i].exp, vt[i].lat);

    // SUB then SRL with ap_start held high
    op = T_SUB; s = 32'd3; e = 32'd5; working_key = LOCK;
    ap_start = 1'b1;
    step();
    op = T_SRL; s = 32'h8000_0000; e = 32'h21;
    chk("b2b_exec", 64'({ap_idle, ap_done}), 64'b00);
    step();
    chk("b2b_sub_done", 64'({ap_done, ap_ready}), 64'b11);
    chk("b2b_sub_val", 64'(ap_return), 64'hFFFF_FFFE);
    step();
    chk("b2b_gap_idle", 64'({ap_idle, ap_done}), 64'b10);
    step();
    ap_start = 1'b0;
    chk("b2b_srl_exec", 64'({ap_idle, ap_done}), 64'b00);
    step();
    chk("b2b_srl_done", 64'(ap_done), 64'd1);
    chk("b2b_srl_val", 64'(ap_return), 64'h4000_0000);
    step();

    // start held through EXEC and DONE: one op only
    dc0 = done_cnt;
    op = T_ADD; s = 32'd10; e = 32'd20; working_key = LOCK;
    ap_start = 1'b1;
    step(); step(); step();
    ap_start = 1'b0;
    repeat (6) step();
    chk("hold_one_done", 64'(done_cnt - dc0), 64'd1);
    chk("hold_val", 64'(ap_return), 64'd30);

    // MUL with start pulsed in EXEC and in DONE
    dc0 = done_cnt;
    op = T_MUL; s = 32'd7; e = 32'd9; ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    repeat (4) step();
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    lat = 6;
    while (!ap_done && lat < 100) begin step(); lat++; end
    chk("pulse_lat", 64'(lat), 64'(W + 1));
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    repeat (40) step();
    chk("pulse_one_done", 64'(done_cnt - dc0), 64'd1);
    chk("pulse_val", 64'(ap_return), 64'd63);

    // Reset in the middle of a MUL
    op = T_MUL; s = 32'h1234; e = 32'h5678; ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    repeat (4) step();
    ap_rst_n = 1'b0;
    #1;
    chk("rst_mid_return", 64'(ap_return), 64'd0);
    chk("rst_mid_flags", 64'({ap_idle, ap_done}), 64'b10);
    step(); step();
    ap_rst_n = 1'b1;
    dc0 = done_cnt;
    repeat (40) step();
    chk("rst_no_done", 64'(done_cnt - dc0), 64'd0);
    chk("rst_idle", 64'(ap_idle), 64'd1);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]    ro;
      logic [W-1:0]  ra, rb;
      logic [KW-1:0] rk;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 2) == 0) rk = LOCK;
      else if ($urandom_range(0, 1) == 0)
        rk = LOCK ^ (KW'(1) << $urandom_range(0, KW - 1));
      else rk = rand_key();
      run_op($sformatf("rnd%0d", i), ro, ra, rb, rk,
             model(ro, ra, rb, rk), (ro == T_MUL) ? W + 1 : 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calculate_multi_obf.md
Name: calculate_multi_obf

Overview:
- Parametrised successor to the single-function locked `calculate` core: a multi-operation, logic-locked ALU with WIDTH-bit operands `s` and `e`.
- Keeps the ap_ctrl_hs start/done/idle/ready handshake.
- Adds a runtime opcode (add/sub/logic/shift/iterative multiply) and key-dependent output corruption.
- Instantiated under the per-key golden wrappers, which tie `working_key` to a constant.

Parameters:
- WIDTH, 32, operand and result width (8..64).
- KEY_WIDTH, 255, working_key width.
- LOCK_KEY, {KEY_WIDTH{1'b0}}, correct unlocking key; overridden per obfuscated instance.

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  request; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse: result valid.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse, identical to ap_done.
- op  in  3  opcode, latched at accept.
- s  in  WIDTH  operand A, latched at accept.
- e  in  WIDTH  operand B, latched at accept.
- working_key  in  KEY_WIDTH  unlock key, latched at accept.
- ap_return  out  WIDTH  registered result; holds until next ap_done.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ap_return=0, ap_done=ap_ready=0, ap_idle=1, internal operand and key registers 0.
- Reset mid-operation abandons the operation; no ap_done is produced.
- States are IDLE, EXEC and DONE.
  - IDLE with ap_start=1 (cycle T): latch op/s/e/working_key, go to EXEC.
  - EXEC lasts N cycles: N=1 for all ops except MUL; N=WIDTH for MUL.
  - DONE lasts 1 cycle: ap_done=ap_ready=1, ap_return updated on entry to DONE, ap_idle=0. DONE always returns to IDLE.
- Latency: ap_done asserted in cycle T+1+N. Non-MUL ops give T+2; MUL at WIDTH=32 gives T+33.
- Throughput: ap_start held high is accepted again in the cycle after DONE, so at least one idle cycle separates operations.
- ap_idle is high only in IDLE. ap_start is ignored in EXEC and DONE. Input changes after accept have no effect.
- Opcodes (pkg), all results WIDTH bits, unsigned, wrapping:
  - 000 ADD: s+e, carry discarded.
  - 001 SUB: s-e, two's-complement wrap.
  - 010 AND, 011 OR, 100 XOR.
  - 101 MUL: low WIDTH bits of s*e, radix-2 shift-add, one partial product per cycle.
  - 110 SLL: s << e[$clog2(WIDTH)-1:0].
  - 111 SRL: logical shift right, same shift amount.
- Locking:
  - diff = working_key ^ LOCK_KEY, zero-padded to a multiple of WIDTH.
  - mask = XOR of all WIDTH-bit chunks of diff.
  - ap_return = raw_result ^ mask.
  - Correct key gives mask=0. A single flipped key bit k inverts result bit (k mod WIDTH).
  - No output indicates key validity.
- The multiplier's accumulator and counter are cleared on every accept, so no state leaks between operations.

Decomposition:
- Package calculate_pkg holds:
  - op encodings (OP_ADD..OP_SRL, 3-bit);
  - state enum {IDLE, EXEC, DONE};
  - function key_fold(diff, WIDTH).
- One natural sub-module, calculate_seq_mul:
  - ports start/busy/done, a, b, product low WIDTH bits;
  - WIDTH-cycle latency;
  - reset and clock shared with the top.
- Single-cycle ops and the key mask stay in the top.

Test Plan:
- Reset during MUL: WIDTH=32, accept MUL, deassert ap_rst_n at T+5 -> ap_return=0, ap_idle=1 immediately; no ap_done after release.
- ADD, correct key: s=0xFFFF_FFFF, e=2 -> ap_done at T+2, ap_return=0x0000_0001, ap_ready coincident, ap_idle low during T+1..T+2.
- MUL, correct key: s=0x0001_0003, e=0x0002_0005 -> ap_done exactly at T+33, ap_return=0x000B_000F (low 32 bits of 0x2_000B_000F).
- SUB then SRL back-to-back, ap_start held high:
  - SUB s=3, e=5 -> 0xFFFF_FFFE at T+2;
  - next accept at T+3;
  - SRL s=0x8000_0000, e=0x21 (shift amount 1) -> 0x4000_0000 at T+5.
- Wrong key, working_key = LOCK_KEY ^ (1<<33): XOR s=0xF0F0_F0F0, e=0x0F0F_0F0F -> ap_return=0xFFFF_FFFD. Operands changed during EXEC -> result unchanged.
- ap_start pulsed during EXEC and during DONE -> ignored; exactly one ap_done per accepted start.
